// File: rtl/int_res_vector_reader_pkg.sv
// Shared types and constants for the integer-result vector reader.
// Bounds checking of issued read addresses is enabled by defining INT_RES_RD_BOUNDS_CHECK_EN.
package Defines;

   localparam int unsigned INT_RES_ADDR_W                 = 16;
   localparam int unsigned VECTOR_LEN_W                   = 7;
   localparam int unsigned N_COMP                         = 32;
   localparam int unsigned Q_COMP                         = 21;
   localparam int unsigned N_STO_INT_RES                  = 15;
   localparam int unsigned Q_STO_INT_RES_DOUBLE           = 20;
   localparam int unsigned CIM_INT_RES_NUM_BANKS          = 7;
   localparam int unsigned CIM_INT_RES_BANK_SIZE_NUM_WORD = 8192;
   localparam int unsigned INT_RES_NUM_WORDS =
      CIM_INT_RES_NUM_BANKS * CIM_INT_RES_BANK_SIZE_NUM_WORD;

   typedef logic [INT_RES_ADDR_W-1:0]    IntResAddr_t;
   typedef logic [VECTOR_LEN_W-1:0]      VectorLen_t;
   typedef logic [N_STO_INT_RES-1:0]     IntResSingle_t;
   typedef logic [2*N_STO_INT_RES-1:0]   IntResDouble_t;
   typedef logic signed [N_COMP-1:0]     CompFx_t;

   typedef enum logic {SINGLE_WIDTH, DOUBLE_WIDTH} DataWidth_t;
   typedef enum logic {HORIZONTAL, VERTICAL} Direction_t;

   typedef enum logic [2:0] {
      SW_FX_1_X,
      SW_FX_2_X,
      SW_FX_4_X,
      SW_FX_5_X,
      SW_FX_6_X,
      INT_RES_DW_FX
   } FxFormatIntRes_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_HI,
      RD_LO,
      WAIT_DATA,
      OUTPUT
   } IntResReaderState_t;

   // Integer bits of a single-width stored format.
   function automatic int unsigned sw_int_bits(FxFormatIntRes_t fmt);
      unique case (fmt)
         SW_FX_1_X: return 1;
         SW_FX_2_X: return 2;
         SW_FX_4_X: return 4;
         SW_FX_5_X: return 5;
         SW_FX_6_X: return 6;
         default:   return 1;
      endcase
   endfunction

endpackage

// File: rtl/int_res_fx_to_comp.sv
// Combinational conversion of a stored integer-result word (single or double width)
// into the compute fixed-point format.
module int_res_fx_to_comp
   import Defines::*;
(
   input  IntResDouble_t   raw,
   input  DataWidth_t      data_width,
   input  FxFormatIntRes_t fx_format,
   output CompFx_t         comp
);

   logic    use_double;
   CompFx_t sw_ext;
   CompFx_t dw_ext;

   always_comb begin
      // A width/format disagreement is resolved towards the double-width interpretation.
      use_double = (data_width == DOUBLE_WIDTH) || (fx_format == INT_RES_DW_FX);
      sw_ext = {{(N_COMP-N_STO_INT_RES){raw[N_STO_INT_RES-1]}}, raw[N_STO_INT_RES-1:0]};
      dw_ext = {{(N_COMP-2*N_STO_INT_RES){raw[2*N_STO_INT_RES-1]}}, raw};
      if (use_double) begin
         comp = dw_ext << (Q_COMP - Q_STO_INT_RES_DOUBLE);
      end else begin
         comp = sw_ext << (Q_COMP - (N_STO_INT_RES - sw_int_bits(fx_format)));
      end
   end

endmodule

// File: rtl/int_res_vector_reader.sv
// Streams a contiguous or strided vector out of integer-result memory, one element per handshake.
// Optional address bounds checking: define INT_RES_RD_BOUNDS_CHECK_EN.
module int_res_vector_reader
   import Defines::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  IntResAddr_t     base_addr,
   input  VectorLen_t      len,
   input  Direction_t      direction,
   input  IntResAddr_t     stride,
   input  DataWidth_t      data_width,
   input  FxFormatIntRes_t fx_format,
   output logic            mem_rd_en,
   output IntResAddr_t     mem_rd_addr,
   input  IntResSingle_t   mem_rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output CompFx_t         out_data,
   output logic            busy,
   output logic            done,
   output logic            err
);

`ifdef INT_RES_RD_BOUNDS_CHECK_EN
   // One extra bit so an address past the end is seen as such instead of wrapping.
   localparam int unsigned AccW = INT_RES_ADDR_W + 1;
`else
   localparam int unsigned AccW = INT_RES_ADDR_W;
`endif

   typedef logic [AccW-1:0] acc_addr_t;

   IntResReaderState_t state_q, state_d;

   acc_addr_t       elem_addr_q, rd_addr, step;
   VectorLen_t      cnt_q;
   Direction_t      dir_q;
   IntResAddr_t     stride_q;
   DataWidth_t      width_q;
   FxFormatIntRes_t fmt_q;
   IntResSingle_t   hi_q;
   CompFx_t         out_data_q, conv_data;
   IntResDouble_t   raw_data;
   logic            done_q, err_q;
   logic            accept, eff_double, fmt_mismatch, bounds_fail, hs;

   assign accept       = (state_q == IDLE) && start;
   assign eff_double   = (data_width == DOUBLE_WIDTH) || (fx_format == INT_RES_DW_FX);
   assign fmt_mismatch = (data_width == DOUBLE_WIDTH) != (fx_format == INT_RES_DW_FX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (start && (len != '0)) state_d = RD_HI;
         RD_HI: begin
            if (bounds_fail)                  state_d = IDLE;
            else if (width_q == DOUBLE_WIDTH) state_d = RD_LO;
            else                              state_d = WAIT_DATA;
         end
         RD_LO:     state_d = bounds_fail ? IDLE : WAIT_DATA;
         WAIT_DATA: state_d = OUTPUT;
         OUTPUT: begin
            if (hs) state_d = (cnt_q == VectorLen_t'(1)) ? IDLE : RD_HI;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_addr = (state_q == RD_LO) ? elem_addr_q + acc_addr_t'(1) : elem_addr_q;
`ifdef INT_RES_RD_BOUNDS_CHECK_EN
      bounds_fail = ((state_q == RD_HI) || (state_q == RD_LO)) &&
                    (rd_addr >= acc_addr_t'(INT_RES_NUM_WORDS));
`else
      bounds_fail = 1'b0;
`endif
      mem_rd_en   = ((state_q == RD_HI) || (state_q == RD_LO)) && !bounds_fail;
      mem_rd_addr = mem_rd_en ? rd_addr[INT_RES_ADDR_W-1:0] : '0;
      out_valid   = (state_q == OUTPUT);
      busy        = (state_q != IDLE);
      hs          = out_valid && out_ready;
   end

   always_comb begin
      if (dir_q == VERTICAL) begin
         step = acc_addr_t'(stride_q);
      end else begin
         step = (width_q == DOUBLE_WIDTH) ? acc_addr_t'(2) : acc_addr_t'(1);
      end
      // In WAIT_DATA the memory presents the last word read: the only word, or the low half.
      raw_data = (width_q == DOUBLE_WIDTH) ? {hi_q, mem_rd_data}
                                           : {{N_STO_INT_RES{1'b0}}, mem_rd_data};
   end

   int_res_fx_to_comp u_fx_to_comp (
      .raw        (raw_data),
      .data_width (width_q),
      .fx_format  (fmt_q),
      .comp       (conv_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         elem_addr_q <= '0;
         cnt_q       <= '0;
         dir_q       <= HORIZONTAL;
         stride_q    <= '0;
         width_q     <= SINGLE_WIDTH;
         fmt_q       <= SW_FX_1_X;
         hi_q        <= '0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            elem_addr_q <= acc_addr_t'(base_addr);
            cnt_q       <= len;
            dir_q       <= direction;
            stride_q    <= stride;
            width_q     <= eff_double ? DOUBLE_WIDTH : SINGLE_WIDTH;
            fmt_q       <= eff_double ? INT_RES_DW_FX : fx_format;
            err_q       <= fmt_mismatch;
            done_q      <= (len == '0);
         end
         if (bounds_fail) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
         end
         if (state_q == RD_LO) hi_q <= mem_rd_data;
         if (state_q == WAIT_DATA) out_data_q <= conv_data;
         if (hs) begin
            if (cnt_q == VectorLen_t'(1)) begin
               done_q <= 1'b1;
            end else begin
               cnt_q       <= cnt_q - VectorLen_t'(1);
               elem_addr_q <= elem_addr_q + step;
            end
         end
      end
   end

   assign out_data = out_data_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_int_res_vector_reader.sv
// Scoreboard bench for int_res_vector_reader: a reference model fills expected read-address
// and element queues; a negedge monitor pops and compares whenever the DUT reads or hands over.
module tb_int_res_vector_reader;
   import Defines::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   IntResAddr_t     base_addr;
   VectorLen_t      len;
   Direction_t      direction;
   IntResAddr_t     stride;
   DataWidth_t      data_width;
   FxFormatIntRes_t fx_format;
   logic            mem_rd_en;
   IntResAddr_t     mem_rd_addr;
   IntResSingle_t   mem_rd_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   CompFx_t         out_data;
   logic            busy, done, err;

   always #5 clk = ~clk;

   int_res_vector_reader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .len         (len),
      .direction   (direction),
      .stride      (stride),
      .data_width  (data_width),
      .fx_format   (fx_format),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   logic [14:0] mem [65536];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int     vectors = 0, miscompares = 0;
   int     cyc = 0;
   int     ready_mode = 0;  // 0: always ready, 1: random, 2: held low
   int     exp_addr_q[$];
   longint exp_data_q[$];
   int     first_rd_cyc, first_valid_cyc, done_cyc, st_cyc;
   int     rd_cnt = 0, hs_cnt = 0, done_cnt = 0, done_base = 0, cur_len = 0;
   bit     cur_exp_err;
   bit     stall_seen = 0;
   longint stall_data;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input longint act, input longint req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compares every read address and every accepted element against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_rd_en) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            check("rd_expected", longint'(exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) check("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
         end
         if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            check("rd_en_while_valid", mem_rd_en, 0);
            if (stall_seen) check("out_data_hold", out_data, stall_data);
            if (out_ready) begin
               hs_cnt++;
               stall_seen = 0;
               check("out_expected", longint'(exp_data_q.size() > 0), 1);
               if (exp_data_q.size() > 0) check("out_data", out_data, exp_data_q.pop_front());
            end else begin
               stall_seen = 1;
               stall_data = out_data;
            end
         end else begin
            stall_seen = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // Reference: walks element addresses and converts stored words by plain arithmetic.
   task automatic model_vec(input int b, input int l, input int d, input int s, input int w,
                            input int f, output bit exp_err);
      bit     dbl;
      longint a, a2, v, val;
      int     step, n;
      dbl     = (w == 1) || (f == 5);
      exp_err = ((w == 1) != (f == 5));
      step    = (d == 0) ? (dbl ? 2 : 1) : s;
      a       = b;
      for (int i = 0; i < l; i++) begin
`ifdef INT_RES_RD_BOUNDS_CHECK_EN
         if (a >= 57344) begin exp_err = 1; break; end
`endif
         exp_addr_q.push_back(int'(a % 65536));
         if (dbl) begin
            a2 = a + 1;
`ifdef INT_RES_RD_BOUNDS_CHECK_EN
            if (a2 >= 57344) begin exp_err = 1; break; end
`else
            a2 = a2 % 65536;
`endif
            exp_addr_q.push_back(int'(a2));
            v = longint'(mem[int'(a % 65536)]) * 32768 + longint'(mem[int'(a2)]);
            if (v >= 536870912) v = v - 1073741824;
            val = v * 2;
         end else begin
            n = (f == 0) ? 1 : (f == 1) ? 2 : (f == 2) ? 4 : (f == 3) ? 5 : 6;
            v = longint'(mem[int'(a % 65536)]);
            if (v >= 16384) v = v - 32768;
            val = v * (longint'(1) << (21 - (15 - n)));
         end
         exp_data_q.push_back(val);
         a = a + step;
`ifndef INT_RES_RD_BOUNDS_CHECK_EN
         a = a % 65536;
`endif
      end
   endtask

   task automatic start_vec(input int b, input int l, input int d, input int s, input int w,
                            input int f);
      bit e;
      model_vec(b, l, d, s, w, f, e);
      cur_exp_err     = e;
      cur_len         = l;
      first_rd_cyc    = -1;
      first_valid_cyc = -1;
      rd_cnt          = 0;
      hs_cnt          = 0;
      done_base       = done_cnt;
      @(posedge clk); #1;
      start      = 1'b1;
      base_addr  = IntResAddr_t'(b);
      len        = VectorLen_t'(l);
      direction  = Direction_t'(d);
      stride     = IntResAddr_t'(s);
      data_width = DataWidth_t'(w);
      fx_format  = FxFormatIntRes_t'(f);
      st_cyc     = cyc;
      @(posedge clk); #1;
      start      = 1'b0;
      // Scramble inputs so anything not latched shows up as a miscompare.
      base_addr  = IntResAddr_t'($urandom);
      len        = VectorLen_t'($urandom_range(0, 64));
      direction  = Direction_t'($urandom_range(0, 1));
      stride     = IntResAddr_t'($urandom);
      data_width = DataWidth_t'($urandom_range(0, 1));
      fx_format  = FxFormatIntRes_t'($urandom_range(0, 5));
   endtask

   task automatic finish_vec(input int valid_lat, input bit timing);
      for (int k = 0; k < 3000 && done_cnt == done_base; k++) @(posedge clk);
      #1;
      check("done_pulses", done_cnt - done_base, 1);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("err", err, cur_exp_err);
      check("reads_pending", exp_addr_q.size(), 0);
      check("elems_pending", exp_data_q.size(), 0);
      if (timing) begin
         if (cur_len == 0) begin
            check("len0_done_latency", done_cyc - st_cyc, 1);
            check("len0_reads", rd_cnt, 0);
            check("len0_valid", first_valid_cyc, -1);
         end else begin
            check("first_read_latency", first_rd_cyc - st_cyc, 1);
            check("first_valid_latency", first_valid_cyc - st_cyc, valid_lat);
         end
      end
      exp_addr_q.delete();
      exp_data_q.delete();
   endtask

   task automatic check_reset_outputs();
      check("rst_mem_rd_en", mem_rd_en, 0);
      check("rst_mem_rd_addr", mem_rd_addr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; direction = HORIZONTAL;
      stride = '0; data_width = SINGLE_WIDTH; fx_format = SW_FX_1_X;
      for (int i = 0; i < 65536; i++) mem[i] = 15'($urandom);
      mem[100] = 15'h2000; mem[101] = 15'h7FFF; mem[102] = 15'h4000;
      mem[0] = 15'h0001; mem[1] = 15'h0000; mem[2] = 15'h7FFF; mem[3] = 15'h7FFF;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      // Contiguous single width, contiguous double width, strided, empty vector.
      start_vec(100, 3, 0, 0, 0, 1);  finish_vec(3, 1);
      start_vec(0, 2, 0, 0, 1, 5);    finish_vec(4, 1);
      start_vec(5, 4, 1, 64, 0, 2);   finish_vec(3, 1);
      start_vec(40, 0, 0, 0, 0, 0);   finish_vec(0, 1);
      // Last word of memory in double width: wraps or trips the bounds check.
      start_vec(57343, 1, 0, 0, 1, 5); finish_vec(0, 0);

      // Back-pressure on element 0, with a start attempt that must be ignored while busy.
      ready_mode = 2;
      start_vec(1000, 3, 0, 0, 0, 4);
      for (int k = 0; k < 50 && first_valid_cyc < 0; k++) @(posedge clk);
      check("stall_reached_valid", longint'(first_valid_cyc >= 0), 1);
      r0 = rd_cnt;
      #1;
      start = 1'b1; base_addr = 16'd7; len = 7'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      check("reads_during_stall", rd_cnt - r0, 0);
      check("handshakes_during_stall", hs_cnt, 0);
      ready_mode = 0;
      finish_vec(0, 0);

      // Reset in the middle of a 5-element vector with a mismatched format.
      start_vec(200, 5, 0, 0, 0, 5);
      for (int k = 0; k < 200 && hs_cnt < 2; k++) @(posedge clk);
      #1;
      check("err_before_abort", err, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs();
      rst_n = 1'b1;
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (4) @(posedge clk);
      check("no_done_after_abort", done_cnt - done_base, 0);
      start_vec(300, 3, 0, 0, 0, 1);  finish_vec(3, 1);

      // Randomized vectors under random back-pressure.
      ready_mode = 1;
      for (int i = 0; i < 40; i++) begin
         start_vec(int'($urandom_range(0, 65535)), (i == 7) ? 64 : int'($urandom_range(1, 10)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 400)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
         finish_vec(0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
